control_unit: RTL and testbench

- Instruction-sequencing FSM for the 16-bit, 8-register processor datapath.
- Latches the instruction word from DIN, steps it through timesteps T0–T3, and drives the bus-mux selects (Rout, Gout, DINout) plus the register/ALU load enables.
- Sits directly upstream of the bus multiplexer. Guarantees at most one bus source is selected in any cycle.

---
 rtl/proc_pkg.sv | 25 ++
 rtl/dec3to8.sv | 16 +
 rtl/control_unit.sv | 114 +++++++++++
 tb/tb_control_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared state encoding, opcodes and instruction field slices
package proc_pkg;

   // Timestep encoding; all four codes are used, so no unreachable states exist
   typedef enum logic [1:0] {
      T0 = 2'b00,
      T1 = 2'b01,
      T2 = 2'b10,
      T3 = 2'b11
   } state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   // Instruction fields III XXX YYY
   localparam int OP_HI = 8;
   localparam int OP_LO = 6;
   localparam int RX_HI = 5;
   localparam int RX_LO = 3;
   localparam int RY_HI = 2;
   localparam int RY_LO = 0;

endpackage

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - 3-to-8 one-hot decoder, MSB-first output (Y[0] is code 0)
module dec3to8 (
   input  logic [2:0] W,
   input  logic       En,
   output logic [0:7] Y
);

   // One-hot decode of W when enabled, all zero otherwise
   always_comb begin
      Y = '0;
      if (En) begin
         Y[W] = 1'b1;
      end
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - instruction-sequencing FSM driving bus selects and load enables
module control_unit
   import proc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IR_W   = 9
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Run,
   input  logic [DATA_W-1:0] DIN,
   output logic [IR_W-1:0]   IR,
   output logic [0:7]        Rout,
   output logic              Gout,
   output logic              DINout,
   output logic [0:7]        Rin,
   output logic              Ain,
   output logic              Gin,
   output logic              AddSub,
   output logic              IRin,
   output logic              Done
);

   state_t      state, next_state;
   logic [2:0]  opcode, rx, ry;
   logic [0:7]  rx_oh, ry_oh;

   // Only the top IR_W bits of DIN form an instruction; the rest is immediate-only data
   logic unused_din_low;
   assign unused_din_low = ^DIN[DATA_W-IR_W-1:0];

   assign opcode = IR[OP_HI:OP_LO];
   assign rx     = IR[RX_HI:RX_LO];
   assign ry     = IR[RY_HI:RY_LO];

   dec3to8 u_dec_rx (.W(rx), .En(1'b1), .Y(rx_oh));
   dec3to8 u_dec_ry (.W(ry), .En(1'b1), .Y(ry_oh));

   // State and instruction register; IR only loads on a T0 fetch with Run high
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= T0;
         IR    <= '0;
      end else begin
         state <= next_state;
         if (state == T0 && Run) begin
            IR <= DIN[DATA_W-1 -: IR_W];
         end
      end
   end

   // Next-state and control decode; at most one bus source is ever selected
   always_comb begin
      next_state = state;
      Rout       = '0;
      Gout       = 1'b0;
      DINout     = 1'b0;
      Rin        = '0;
      Ain        = 1'b0;
      Gin        = 1'b0;
      AddSub     = 1'b0;
      IRin       = 1'b0;
      Done       = 1'b0;
      case (state)
         T0: begin
            IRin = Run & ~Reset;
            if (Run) begin
               next_state = T1;
            end
         end
         T1: begin
            case (opcode)
               OP_MV: begin
                  Rout       = ry_oh;
                  Rin        = rx_oh;
                  Done       = 1'b1;
                  next_state = T0;
               end
               OP_MVI: begin
                  DINout     = 1'b1;
                  Rin        = rx_oh;
                  Done       = 1'b1;
                  next_state = T0;
               end
               OP_ADD, OP_SUB: begin
                  Rout       = rx_oh;
                  Ain        = 1'b1;
                  next_state = T2;
               end
               default: begin
                  Done       = 1'b1;
                  next_state = T0;
               end
            endcase
         end
         T2: begin
            Rout       = ry_oh;
            Gin        = 1'b1;
            AddSub     = (opcode == OP_SUB);
            next_state = T3;
         end
         T3: begin
            Gout       = 1'b1;
            Rin        = rx_oh;
            Done       = 1'b1;
            next_state = T0;
         end
         default: begin
            next_state = T0;
         end
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit
module tb_control_unit;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Run;
   logic [15:0] DIN;
   logic [8:0]  IR;
   logic [0:7]  Rout;
   logic        Gout;
   logic        DINout;
   logic [0:7]  Rin;
   logic        Ain;
   logic        Gin;
   logic        AddSub;
   logic        IRin;
   logic        Done;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];
   logic [8:0]  exp_ir;

   control_unit dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Run    (Run),
      .DIN    (DIN),
      .IR     (IR),
      .Rout   (Rout),
      .Gout   (Gout),
      .DINout (DINout),
      .Rin    (Rin),
      .Ain    (Ain),
      .Gin    (Gin),
      .AddSub (AddSub),
      .IRin   (IRin),
      .Done   (Done)
   );

   always #5 Clock = ~Clock;

   // Bus exclusivity on every cycle
   always @(negedge Clock) begin
      checks++;
      assert (($countones(Rout) + 32'(Gout) + 32'(DINout)) <= 1) else begin
         errors++;
         $error("FAIL bus_excl observed Rout=%b Gout=%b DINout=%b expected at most one source", Rout, Gout, DINout);
      end
   end

   function automatic logic [7:0] oh(input logic [2:0] r);
      return 8'h80 >> r;
   endfunction

   function automatic logic [31:0] pack(input logic [8:0] ir, input logic [7:0] rout,
                                        input logic gout, input logic dinout, input logic [7:0] rin,
                                        input logic ain, input logic gin, input logic addsub,
                                        input logic irin, input logic done);
      return {ir, rout, gout, dinout, rin, ain, gin, addsub, irin, done};
   endfunction

   function automatic logic [15:0] rand16();
      return 16'($urandom);
   endfunction

   function automatic logic [31:0] idle_vec(input logic [8:0] ir);
      return pack(ir, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   task automatic check_pop();
      logic [31:0] obs;
      logic [31:0] ev;
      string       t;
      obs = {IR, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, IRin, Done};
      ev  = exp_q.pop_front();
      t   = tag_q.pop_front();
      checks++;
      assert (obs === ev) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", t, obs, ev);
      end
   endtask

   task automatic step(input logic run, input logic [15:0] din, input logic [31:0] ev, input string tag);
      Run = run;
      DIN = din;
      exp_q.push_back(ev);
      tag_q.push_back(tag);
      @(negedge Clock);
      check_pop();
      @(posedge Clock);
      #1;
   endtask

   task automatic exec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [15:0] imm, input logic hold, input string tag);
      logic [8:0] ni;
      ni = {op, rx, ry};
      step(1'b1, {ni, 7'h00}, pack(exp_ir, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), {tag, "_t0"});
      exp_ir = ni;
      case (op)
         3'b000: step(hold, rand16(), pack(exp_ir, oh(ry), 1'b0, 1'b0, oh(rx), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), {tag, "_mv_t1"});
         3'b001: step(hold, imm, pack(exp_ir, 8'h00, 1'b0, 1'b1, oh(rx), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), {tag, "_mvi_t1"});
         3'b010, 3'b011: begin
            step(hold, rand16(), pack(exp_ir, oh(rx), 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), {tag, "_alu_t1"});
            step(hold, rand16(), pack(exp_ir, oh(ry), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, op[0], 1'b0, 1'b0), {tag, "_alu_t2"});
            step(hold, rand16(), pack(exp_ir, 8'h00, 1'b1, 1'b0, oh(rx), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), {tag, "_alu_t3"});
         end
         default: step(hold, rand16(), pack(exp_ir, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), {tag, "_ill_t1"});
      endcase
   endtask

   initial begin
      Reset  = 1'b1;
      Run    = 1'b0;
      DIN    = 16'h0000;
      exp_ir = 9'h000;
      @(posedge Clock);
      #1;
      step(1'b0, 16'h0000, idle_vec(9'h000), "reset_state");
      step(1'b1, 16'hFFFF, idle_vec(9'h000), "reset_run_high");
      Reset = 1'b0;

      // Reset asserted mid-T2 of add R1,R2
      step(1'b1, {9'b010_001_010, 7'h00}, pack(9'h000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), "rst_add_t0");
      exp_ir = 9'b010_001_010;
      step(1'b0, 16'h1234, pack(exp_ir, oh(3'd1), 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "rst_add_t1");
      Run = 1'b0;
      exp_q.push_back(pack(exp_ir, oh(3'd2), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      tag_q.push_back("rst_add_t2");
      @(negedge Clock);
      check_pop();
      #2;
      Reset = 1'b1;
      #1;
      exp_ir = 9'h000;
      exp_q.push_back(idle_vec(9'h000));
      tag_q.push_back("rst_async");
      check_pop();
      @(posedge Clock);
      #1;
      step(1'b0, 16'h0000, idle_vec(9'h000), "rst_hold");
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, rand16(), idle_vec(9'h000), "rst_idle");
      end

      // mvi R2,#0x00A5
      exec(3'b001, 3'd2, 3'd0, 16'h00A5, 1'b0, "mvi_r2");
      step(1'b0, 16'h00A5, idle_vec(exp_ir), "mvi_back_t0");

      // mv R7,R1
      exec(3'b000, 3'd7, 3'd1, 16'h0000, 1'b0, "mv_r7_r1");

      // sub R4,R5
      exec(3'b011, 3'd4, 3'd5, 16'h0000, 1'b0, "sub_r4_r5");
      step(1'b0, 16'h0000, idle_vec(exp_ir), "sub_back_t0");

      // Back-to-back with Run held high: add R0,R1 then mv R3,R0
      exec(3'b010, 3'd0, 3'd1, 16'h0000, 1'b1, "b2b_add");
      exec(3'b000, 3'd3, 3'd0, 16'h0000, 1'b1, "b2b_mv");

      // mv R3,R3 - same register source and destination
      exec(3'b000, 3'd3, 3'd3, 16'h0000, 1'b0, "mv_r3_r3");

      // Illegal opcode 101
      exec(3'b101, 3'd6, 3'd2, 16'h0000, 1'b0, "illegal_101");
      step(1'b0, 16'h0000, idle_vec(exp_ir), "illegal_back_t0");

      // Random instructions and Run patterns
      for (int n = 0; n < 500; n++) begin
         exec(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              rand16(), 1'($urandom_range(0, 1)), "rand");
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            step(1'b0, rand16(), idle_vec(exp_ir), "rand_idle");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
